alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised successor to the team's fixed-width ALU: XLEN-wide integer ALU with valid/ready
//  handshakes on input and output, registered result, and an optional iterative multiplier.
//  Sits between decode/issue and writeback in the RISC-V datapath; backpressure-safe for stalls.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, power of 2)
//  OPW    4   opcode width
// PORTS
//  clk         in   1     single clock, rising edge
//  rst         in   1     asynchronous, active-low reset
//  in_valid    in   1     operation offered
//  in_ready    out  1     block can accept; transfer when in_valid && in_ready
//  instr       in   OPW   opcode (alu_pkg::alu_op_e)
//  op1, op2    in   XLEN  operands
//  out_valid   out  1     result valid; held stable until out_ready
//  out_ready   in   1     consumer accepts; transfer when out_valid && out_ready
//  result      out  XLEN  result
//  instr_exec  out  OPW   opcode that produced result
//  illegal     out  1     undefined opcode (result forced 0)
//  zero        out  1     result == 0
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; out_valid=0, result=0, instr_exec=0, illegal=0, zero=1,
//   in_ready=0 while rst=0. Reset mid-multiply abandons the operation; no output is produced.
//  Opcodes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, MUL 10.
//   11..15 are illegal.
//  Arithmetic wraps modulo 2^XLEN. Shift amount = op2[$clog2(XLEN)-1:0].
//   SLT is signed and SLTU unsigned; each returns 0 or 1. MUL returns the low XLEN bits.
//  FSM states:
//   IDLE: in_ready = !out_valid || out_ready.
//    A single-cycle op (or an illegal op) accepted at edge N gives out_valid=1 and result at N+1,
//    giving latency 1 and one op per cycle under continuous out_ready.
//    An accepted MUL latches its operands and goes to MUL.
//   MUL: in_ready=0. Shift-add, one bit per cycle, cycle counter runs 0..XLEN-1.
//    After XLEN cycles the result is loaded, out_valid=1, state returns to IDLE.
//    If out_valid is still set from a prior op, the result waits in MUL until that op drains.
//  Output hold: while out_valid && !out_ready, result, instr_exec, illegal and zero do not change.
//  Accept and drain in the same cycle: the new result replaces the old one; out_valid stays 1.
//  in_valid while in_ready=0 is ignored; the source holds the operation.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL implemented as above, latency XLEN+1 cycles.
//  ALU_MUL_EN undefined: no MUL state or datapath. Opcode 10 is treated as illegal:
//   illegal=1, result=0, latency 1.
// STRUCTURE
//  alu_pkg: alu_op_e enum (OPW bits), alu_state_e {IDLE, MUL}, opcode constants.
//  The same package is shared with the testbench transaction class.
//  Sub-module alu_mul_iter (`ifdef ALU_MUL_EN): start/done interface, XLEN-cycle shift-add
//  multiplier. The combinational op mux and output register stay in alu_pipe.
// TESTING (XLEN=32)
//  1. ADD 0xFFFFFFFF+0x1, out_ready=1 -> next cycle result=0, zero=1, out_valid=1, instr_exec=0.
//  2. Back-to-back SUB 5-7, SRA 0x80000000>>4, SLTU 1<0xFFFFFFFF with out_ready=1 ->
//     results 0xFFFFFFFE, 0xF8000000, 1 on consecutive cycles.
//  3. Hold out_ready=0 for 3 cycles after an XOR -> in_ready=0 and result stable;
//     on release it drains, and a pending op is accepted in the same cycle.
//  4. MUL 0x10000 * 0x10001 (ALU_MUL_EN) -> out_valid after 33 cycles, result=0x00010000;
//     in_ready=0 throughout the MUL.
//  5. Opcode 0xC, plus opcode 10 with ALU_MUL_EN undefined -> illegal=1, result=0, latency 1.
//  6. Assert rst=0 mid-MUL at cycle 10 -> all outputs reset asynchronously;
//     after release no stale result appears and a new ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the pipelined ALU and its testbench.
package alu_pkg;

    localparam int OPW_DEF = 4;

    typedef enum logic [OPW_DEF-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; built only with ALU_MUL_EN.
// done rises XLEN cycles after start and stays high until the next start.
`ifdef ALU_MUL_EN
module alu_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic            busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            product <= '0;
            mcand   <= a;
            mplier  <= b;
            cnt     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (busy) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_pipe.sv
// XLEN-wide integer ALU with valid/ready on both sides and a registered result.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise opcode 10 is illegal.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  instr,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [OPW-1:0]  instr_exec,
    output logic            illegal,
    output logic            zero
);
    localparam int SHW = $clog2(XLEN);

    logic            accept;
    logic            can_load;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [SHW-1:0]  shamt;

    assign shamt    = op2[SHW-1:0];
    assign can_load = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
    alu_state_e      state;
    logic            is_mul;
    logic            mul_done;
    logic [XLEN-1:0] mul_prod;

    assign is_mul   = (instr == OPW'(OP_MUL));
    assign in_ready = rst && (state == IDLE) && can_load;

    alu_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (op1),
        .b       (op2),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign in_ready = rst && can_load;
`endif

    // MUL decodes as legal here; its value comes from the multiplier, not this mux.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (instr)
            OPW'(OP_ADD):  alu_res = op1 + op2;
            OPW'(OP_SUB):  alu_res = op1 - op2;
            OPW'(OP_AND):  alu_res = op1 & op2;
            OPW'(OP_OR):   alu_res = op1 | op2;
            OPW'(OP_XOR):  alu_res = op1 ^ op2;
            OPW'(OP_SLL):  alu_res = op1 << shamt;
            OPW'(OP_SRL):  alu_res = op1 >> shamt;
            OPW'(OP_SRA):  alu_res = $signed(op1) >>> shamt;
            OPW'(OP_SLT):  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OPW'(OP_SLTU): alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
`ifdef ALU_MUL_EN
            OPW'(OP_MUL):  alu_res = '0;
`endif
            default:       alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
`ifdef ALU_MUL_EN
            state      <= IDLE;
`endif
            out_valid  <= 1'b0;
            result     <= '0;
            instr_exec <= '0;
            illegal    <= 1'b0;
            zero       <= 1'b1;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef ALU_MUL_EN
            if (state == MUL) begin
                // Finished product waits here until the output slot is free.
                if (mul_done && can_load) begin
                    out_valid  <= 1'b1;
                    result     <= mul_prod;
                    instr_exec <= OPW'(OP_MUL);
                    illegal    <= 1'b0;
                    zero       <= (mul_prod == '0);
                    state      <= IDLE;
                end
            end else if (accept) begin
                if (is_mul) begin
                    state <= MUL;
                end else begin
                    out_valid  <= 1'b1;
                    result     <= alu_res;
                    instr_exec <= instr;
                    illegal    <= alu_ill;
                    zero       <= (alu_res == '0);
                end
            end
`else
            if (accept) begin
                out_valid  <= 1'b1;
                result     <= alu_res;
                instr_exec <= instr;
                illegal    <= alu_ill;
                zero       <= (alu_res == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (XLEN=32): directed table, handshake corner cases,
// and randomized traffic scored against a queue-based reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  instr = 4'd0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  instr_exec;
    logic        illegal;
    logic        zero;

    int checks = 0;
    int errors = 0;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_pipe #(.XLEN(32), .OPW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .op1        (op1),
        .op2        (op2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .instr_exec (instr_exec),
        .illegal    (illegal),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: the architectural meaning of each opcode, in plain arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int unsigned s;
        longint unsigned p;
        s = int'(b % 32);
        e.op = op;
        e.ill = 1'b0;
        e.res = '0;
        case (op)
            4'd0: e.res = 32'(longint'(a) + longint'(b));
            4'd1: e.res = 32'(longint'(a) + (64'h1_0000_0000 - longint'(b)));
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = 32'(longint'(a) * (64'd1 << s));
            4'd6: e.res = a / (32'd1 << s);
            4'd7: begin
                e.res = a / (32'd1 << s);
                if (a >= 32'h8000_0000 && s != 0) e.res = e.res | ~(32'hFFFF_FFFF >> s);
            end
            4'd8: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: e.res = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                if (MUL_EN) begin
                    p = longint'(a) * longint'(b);
                    e.res = p[31:0];
                end else begin
                    e.ill = 1'b1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic idle_drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    vec_t vt[$];
    exp_t q[$];

    initial begin
        exp_t e;
        exp_t got;
        bit   mul_busy;
        bit   last_acc;
        bit   prev_single;
        bit   held;
        logic [31:0] h_res;
        logic [3:0]  h_op;
        logic        h_ill;
        logic        h_zero;
        int          lat;
        int          stale;

        vt.push_back('{4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0});
        vt.push_back('{4'd1, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0});
        vt.push_back('{4'd7, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0});
        vt.push_back('{4'd9, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0});
        vt.push_back('{4'd8, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0});
        vt.push_back('{4'd8, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0});
        vt.push_back('{4'd6, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0});
        vt.push_back('{4'd5, 32'd1,         32'h23,        32'd8,         1'b0});
        vt.push_back('{4'd7, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0});
        vt.push_back('{4'd2, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0});
        vt.push_back('{4'd3, 32'hF0F0,      32'h0F0F,      32'hFFFF,      1'b0});
        vt.push_back('{4'd4, 32'hFFFF,      32'hFFFF,      32'h0,         1'b0});
        vt.push_back('{4'hC, 32'd5,         32'd6,         32'h0,         1'b1});
        vt.push_back('{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1});
        if (!MUL_EN) vt.push_back('{4'd10, 32'd3, 32'd4, 32'h0, 1'b1});

        // Reset values, with an operation offered during reset.
        in_valid = 1'b1;
        instr = 4'd0; op1 = 32'd1; op2 = 32'd1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", zero, 1'b1);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_instr_exec", instr_exec, 4'h0);
        chk("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        idle_drain(2);

        // Directed table, back to back with out_ready held high.
        foreach (vt[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr = vt[i].op; op1 = vt[i].a; op2 = vt[i].b;
            out_ready = 1'b1;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), out_valid, 1'b1);
            chk($sformatf("tbl%0d_result", i), result, vt[i].res);
            chk($sformatf("tbl%0d_zero", i), zero, (vt[i].res == 32'h0));
            chk($sformatf("tbl%0d_illegal", i), illegal, vt[i].ill);
            chk($sformatf("tbl%0d_instr_exec", i), instr_exec, vt[i].op);
        end
        idle_drain(2);
        #1;
        chk("drained_out_valid", out_valid, 1'b0);

        // Output hold under backpressure, then drain and accept in the same cycle.
        @(negedge clk);
        in_valid = 1'b1; instr = 4'd4; op1 = 32'h1234_5678; op2 = 32'h0F0F_0F0F;
        out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instr = 4'd0; op1 = 32'd2; op2 = 32'd3;
            out_ready = 1'b0;
            #1;
            chk($sformatf("hold%0d_in_ready", i), in_ready, 1'b0);
            chk($sformatf("hold%0d_out_valid", i), out_valid, 1'b1);
            chk($sformatf("hold%0d_result", i), result, 32'h1D3B_5977);
            chk($sformatf("hold%0d_instr_exec", i), instr_exec, 4'd4);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("release_out_valid", out_valid, 1'b1);
        chk("release_result", result, 32'd5);
        chk("release_instr_exec", instr_exec, 4'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("release_drained", out_valid, 1'b0);

`ifdef ALU_MUL_EN
        // Multiplier latency and in_ready low while it runs.
        @(negedge clk);
        in_valid = 1'b1; instr = 4'd10; op1 = 32'h1_0000; op2 = 32'h1_0001;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 0;
        stale = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            in_valid = 1'b1; instr = 4'd0;
            out_ready = 1'b0;
            #1;
            if (!out_valid && in_ready) stale++;
            @(posedge clk);
            #1;
            if (out_valid) lat = k;
        end
        chk("mul_in_ready_low", stale, 0);
        chk("mul_latency", lat, 33);
        chk("mul_result", result, 32'h0001_0000);
        chk("mul_instr_exec", instr_exec, 4'd10);
        @(negedge clk);
        in_valid = 1'b0;
        idle_drain(2);

        // Reset ten cycles into a multiply.
        @(negedge clk);
        in_valid = 1'b1; instr = 4'd10; op1 = 32'd6; op2 = 32'd7;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
`else
        // Reset while a held result sits on the output.
        @(negedge clk);
        in_valid = 1'b1; instr = 4'd0; op1 = 32'd7; op2 = 32'd9;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_result", result, 32'd16);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
`endif
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_result", result, 32'h0);
        chk("async_rst_zero", zero, 1'b1);
        chk("async_rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        stale = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        chk("post_rst_no_stale", stale, 0);
        @(negedge clk);
        in_valid = 1'b1; instr = 4'd0; op1 = 32'd2; op2 = 32'd3;
        @(posedge clk);
        #1;
        chk("post_rst_add_valid", out_valid, 1'b1);
        chk("post_rst_add_result", result, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        idle_drain(2);

        // Randomized traffic with random backpressure, scored against the model.
        mul_busy = 1'b0;
        last_acc = 1'b1;
        prev_single = 1'b0;
        held = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (cyc >= 1400) begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end else begin
                if (!in_valid || last_acc) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    instr = 4'($urandom_range(0, 15));
                    op1 = rand_operand();
                    op2 = rand_operand();
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (out_valid && q.size() > 0 && q[0].op == 4'd10 && !q[0].ill) mul_busy = 1'b0;
            chk("rnd_in_ready", in_ready, !mul_busy && (!out_valid || out_ready));
            if (prev_single) chk("rnd_latency1", out_valid, 1'b1);
            if (held) begin
                chk("rnd_hold_valid", out_valid, 1'b1);
                chk("rnd_hold_result", result, h_res);
                chk("rnd_hold_instr", instr_exec, h_op);
                chk("rnd_hold_flags", {illegal, zero}, {h_ill, h_zero});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_output", 1'b1, 1'b0);
                end else begin
                    got = q.pop_front();
                    chk("rnd_result", result, got.res);
                    chk("rnd_instr_exec", instr_exec, got.op);
                    chk("rnd_illegal", illegal, got.ill);
                    chk("rnd_zero", zero, (got.res == 32'h0));
                end
            end
            held = out_valid && !out_ready;
            h_res = result; h_op = instr_exec; h_ill = illegal; h_zero = zero;
            last_acc = in_valid && in_ready;
            prev_single = 1'b0;
            if (last_acc) begin
                e = model(instr, op1, op2);
                q.push_back(e);
                if (instr == 4'd10 && !e.ill) mul_busy = 1'b1;
                else prev_single = 1'b1;
            end
        end
        chk("rnd_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
